seq_entry_fsm: RTL

Input stage that feeds the board top level's 4-bit sequence attribution logic. Debounces one raw pushbutton and captures a SEQ_LEN-digit sequence of 4-bit values from the switches, one digit per press. On the last digit it compares the entered sequence against a reference code and reports match or fail. The entered digits and the flags drive LEDR and HEX0..HEX5 downstream.

---
 rtl/seq_entry_fsm.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_entry_fsm.sv
// seq_entry_fsm: debounced pushbutton digit entry and reference-code compare.
// Define SEQ_LOCKOUT_EN to add a lockout after three consecutive failures.
module seq_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int SEQ_LEN         = 4,
    parameter int LOCKOUT_CYCLES  = 500000000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 key_n,
    input  logic [3:0]           sw_digit,
    input  logic [4*SEQ_LEN-1:0] code,
    output logic [4*SEQ_LEN-1:0] digits,
    output logic [2:0]           count,
    output logic                 busy,
    output logic                 match,
    output logic                 fail,
    output logic                 locked
);

    localparam int DW  = 4 * SEQ_LEN;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     LEN     = 3'(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_CHECK,
        S_RESULT,
        S_LOCKED
    } state_e;

    logic           key_s1_q;
    logic           key_s2_q;
    logic           key_db_q;
    logic           press_q;
    logic [DBW-1:0] db_cnt_q;
    logic           db_flip;

    // Debounced level only moves after DEBOUNCE_CYCLES stable differing samples.
    assign db_flip = (key_s2_q != key_db_q) && (db_cnt_q == DB_LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            key_db_q <= 1'b1;
            press_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            press_q  <= db_flip && key_db_q;
            if (key_s2_q == key_db_q) begin
                db_cnt_q <= '0;
            end else if (db_flip) begin
                db_cnt_q <= '0;
                key_db_q <= key_s2_q;
            end else begin
                db_cnt_q <= db_cnt_q + DBW'(1);
            end
        end
    end

    state_e         state_q, state_d;
    logic [DW-1:0]  digits_q, digits_d;
    logic [2:0]     count_q, count_d;
    logic           match_q, match_d;
    logic           fail_q, fail_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [DW+3:0]  shifted;

    assign shifted = {digits_q, sw_digit};

`ifdef SEQ_LOCKOUT_EN
    localparam int LKW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LKW-1:0] LK_LAST = LKW'(LOCKOUT_CYCLES - 1);

    logic [1:0]     fcnt_q, fcnt_d;
    logic [LKW-1:0] lk_cnt_q, lk_cnt_d;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            fcnt_q   <= '0;
            lk_cnt_q <= '0;
        end else begin
            fcnt_q   <= fcnt_d;
            lk_cnt_q <= lk_cnt_d;
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            count_q  <= '0;
            match_q  <= 1'b0;
            fail_q   <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            match_q  <= match_d;
            fail_q   <= fail_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        match_d  = match_q;
        fail_d   = fail_q;
        to_cnt_d = to_cnt_q;
`ifdef SEQ_LOCKOUT_EN
        fcnt_d   = fcnt_q;
        lk_cnt_d = lk_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    digits_d = shifted[DW-1:0];
                    count_d  = 3'd1;
                    to_cnt_d = '0;
                    state_d  = (SEQ_LEN == 1) ? S_CHECK : S_ENTER;
                end
            end
            S_ENTER: begin
                if (press_q) begin
                    digits_d = shifted[DW-1:0];
                    count_d  = count_q + 3'd1;
                    to_cnt_d = '0;
                    if (count_q + 3'd1 == LEN) begin
                        state_d = S_CHECK;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    fail_d  = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                end
            end
            S_CHECK: begin
                match_d = (digits_q == code);
                fail_d  = (digits_q != code);
                state_d = S_RESULT;
            end
            S_RESULT: begin
                // The clearing press is consumed; its digit is not captured.
                if (press_q) begin
                    digits_d = '0;
                    count_d  = '0;
                    match_d  = 1'b0;
                    fail_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
`ifdef SEQ_LOCKOUT_EN
            S_LOCKED: begin
                if (lk_cnt_q == LK_LAST) begin
                    digits_d = '0;
                    count_d  = '0;
                    fail_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    lk_cnt_d = lk_cnt_q + LKW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SEQ_LOCKOUT_EN
        if (state_q == S_CHECK && !fail_d) begin
            fcnt_d = '0;
        end
        // A rising fail flag marks a fresh failed result (mismatch or timeout).
        if (fail_d && !fail_q) begin
            if (fcnt_q == 2'd2) begin
                state_d  = S_LOCKED;
                digits_d = '0;
                count_d  = '0;
                match_d  = 1'b0;
                fcnt_d   = '0;
                lk_cnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 2'd1;
            end
        end
`endif
    end

    assign digits = digits_q;
    assign count  = count_q;
    assign match  = match_q;
    assign fail   = fail_q;
    assign busy   = (state_q == S_ENTER) || (state_q == S_CHECK);
`ifdef SEQ_LOCKOUT_EN
    assign locked = (state_q == S_LOCKED);
`else
    assign locked = 1'b0;
`endif

endmodule
